// File: rtl/msg_reader_pkg.sv
// Shared types and constants for the ROM message reader.
package msg_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        CR,
        LF,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] DEFAULT_TERM = 8'h00;

endpackage

// File: rtl/rom_msg_reader.sv
// Streams one terminated message out of a 256x8 synchronous ROM onto a valid/ready byte stream.
// Optional CR/LF trailer after each message is enabled by defining MSG_READER_CRLF_EN.
module rom_msg_reader
    import msg_reader_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = DEFAULT_TERM,
    parameter int         MAX_LEN   = 64,
    localparam int        CW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    msg_addr,
    output logic [7:0]    rom_addr,
    input  logic [7:0]    rom_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] msg_len
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    state_t        state, state_next;
    logic [7:0]    addr_next, data_next;
    logic          valid_next;
    logic [CW-1:0] count, count_next, len_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            count    <= '0;
            msg_len  <= '0;
        end else begin
            state    <= state_next;
            rom_addr <= addr_next;
            tx_data  <= data_next;
            tx_valid <= valid_next;
            count    <= count_next;
            msg_len  <= len_next;
        end
    end

    // The end of a message (terminator or length cap) either goes straight to
    // DONE or first presents the CR byte of the trailer.
    always_comb begin
        state_next = state;
        addr_next  = rom_addr;
        data_next  = tx_data;
        valid_next = tx_valid;
        count_next = count;
        len_next   = msg_len;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_next  = msg_addr;
                    count_next = '0;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                if (rom_data == TERM_CHAR) begin
`ifdef MSG_READER_CRLF_EN
                    data_next  = ASCII_CR;
                    valid_next = 1'b1;
                    state_next = CR;
`else
                    state_next = DONE;
`endif
                end else begin
                    data_next  = rom_data;
                    valid_next = 1'b1;
                    addr_next  = rom_addr + 8'd1;
                    count_next = count + CW'(1);
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    valid_next = 1'b0;
                    if (count == MAX_CNT) begin
`ifdef MSG_READER_CRLF_EN
                        data_next  = ASCII_CR;
                        valid_next = 1'b1;
                        state_next = CR;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
`ifdef MSG_READER_CRLF_EN
            CR: begin
                if (tx_ready) begin
                    data_next  = ASCII_LF;
                    state_next = LF;
                end
            end
            LF: begin
                if (tx_ready) begin
                    valid_next = 1'b0;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                len_next   = count;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rom_msg_reader.sv
// Directed bench for rom_msg_reader with a behavioural 256x8 synchronous ROM.
// Expected trailers follow MSG_READER_CRLF_EN when it is defined for the build.
module tb_rom_msg_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] msg_addr;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [2:0] msg_len;

    logic [7:0] rom [256];

    int         checks = 0;
    int         errors = 0;

    int         neg_idx = 0;
    int         start_idx;
    int         first_valid_idx;
    int         done_idx;
    int         done_cnt;
    logic [7:0] max_addr;
    logic [7:0] prev_addr = 8'h00;
    bit         wrap_seen;
    logic [7:0] rx_q[$];
    int         acc_idx[$];
    logic [7:0] exp_q[$];

`ifdef MSG_READER_CRLF_EN
    localparam int EMPTY_DONE_LAT = 5;
`else
    localparam int EMPTY_DONE_LAT = 3;
`endif

    rom_msg_reader #(.TERM_CHAR(8'h00), .MAX_LEN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .msg_addr (msg_addr),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .msg_len  (msg_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // Passive observer: everything is sampled on the falling edge.
    always @(negedge clk) begin
        neg_idx++;
        if (start && !busy && start_idx < 0) start_idx = neg_idx;
        if (tx_valid && first_valid_idx < 0) first_valid_idx = neg_idx;
        if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            acc_idx.push_back(neg_idx);
        end
        if (done) begin
            done_cnt++;
            done_idx = neg_idx;
        end
        if (busy && rom_addr > max_addr) max_addr = rom_addr;
        if (busy && prev_addr == 8'hFF && rom_addr == 8'h00) wrap_seen = 1'b1;
        prev_addr = rom_addr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearRecords();
        start_idx       = -1;
        first_valid_idx = -1;
        done_idx        = -1;
        done_cnt        = 0;
        max_addr        = 8'h00;
        wrap_seen       = 1'b0;
        rx_q.delete();
        acc_idx.delete();
    endtask

    task automatic addTrailer();
`ifdef MSG_READER_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic waitValid();
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        checkOutput("valid_timeout", tx_valid, 1);
    endtask

    task automatic waitDone();
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", done_cnt > 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Launch one message; optionally stall the first byte and pulse a second start during the stall.
    task automatic applyStimulus(input logic [7:0] addr, input int stall, input bit restart);
        clearRecords();
        @(posedge clk); #1;
        msg_addr = addr;
        start    = 1'b1;
        if (stall > 0) tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (stall > 0) begin
            waitValid();
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                checkOutput($sformatf("stall_valid_%0d", i), tx_valid, 1);
                checkOutput($sformatf("stall_data_%0d", i), tx_data, exp_q[0]);
            end
            if (restart) begin
                @(posedge clk); #1;
                msg_addr = 8'h30;
                start    = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(posedge clk); #1;
            tx_ready = 1'b1;
        end
        waitDone();
    endtask

    task automatic checkMessage(input string tag, input int exp_len);
        checkOutput({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size())
                checkOutput($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        checkOutput({tag, "_msg_len"}, msg_len, exp_len);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h2E;
        rom[8'h10] = 8'h48; rom[8'h11] = 8'h49; rom[8'h12] = 8'h00;
        rom[8'hFE] = 8'h41; rom[8'hFF] = 8'h42; rom[8'h00] = 8'h43; rom[8'h01] = 8'h00;
        for (int i = 0; i < 10; i++) rom[8'h20 + i] = 8'h61 + 8'(i);
        rom[8'h30] = 8'h4F; rom[8'h31] = 8'h4B; rom[8'h32] = 8'h00;
        rom[8'h40] = 8'h00;

        rst_n    = 1'b0;
        start    = 1'b0;
        msg_addr = 8'h00;
        tx_ready = 1'b1;
        clearRecords();

        #12;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rom_addr", rom_addr, 8'h00);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_msg_len", msg_len, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // "HI" with consumer always ready: latency and 3-cycle spacing
        exp_q = {8'h48, 8'h49};
        addTrailer();
        applyStimulus(8'h10, 0, 1'b0);
        checkMessage("hi", 2);
        checkOutput("hi_start_to_valid", first_valid_idx - start_idx, 3);
        if (acc_idx.size() >= 2) checkOutput("hi_spacing", acc_idx[1] - acc_idx[0], 3);
        else checkOutput("hi_spacing_count", acc_idx.size(), 2);

        // Same message, first byte stalled for 5 cycles
        applyStimulus(8'h10, 5, 1'b0);
        checkMessage("hi_stall", 2);

        // Address wrap 0xFF -> 0x00
        exp_q = {8'h41, 8'h42, 8'h43};
        addTrailer();
        applyStimulus(8'hFE, 0, 1'b0);
        checkMessage("wrap", 3);
        checkOutput("wrap_seen", wrap_seen, 1);

        // Length cap of 4 on an unterminated run at 0x20
        exp_q = {8'h61, 8'h62, 8'h63, 8'h64};
        addTrailer();
        applyStimulus(8'h20, 0, 1'b0);
        checkMessage("cap", 4);
        checkOutput("cap_max_addr", max_addr, 8'h24);

        // Empty message
        exp_q = {};
        addTrailer();
        applyStimulus(8'h40, 0, 1'b0);
        checkMessage("empty", 0);
        checkOutput("empty_done_lat", done_idx - start_idx, EMPTY_DONE_LAT);

        // Second start while sending must be dropped, not queued
        exp_q = {8'h48, 8'h49};
        addTrailer();
        applyStimulus(8'h10, 3, 1'b1);
        checkMessage("restart", 2);
        repeat (10) @(negedge clk);
        checkOutput("restart_no_queue_busy", busy, 0);
        checkOutput("restart_no_queue_done", done_cnt, 1);

        // Reset in the middle of a stalled message
        clearRecords();
        @(posedge clk); #1;
        msg_addr = 8'h20;
        start    = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        waitValid();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx_valid", tx_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_rom_addr", rom_addr, 8'h00);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_done", done_cnt, 0);
        checkOutput("midrst_no_bytes", rx_q.size(), 0);

        // Fresh message after reset
        exp_q = {8'h4F, 8'h4B};
        addTrailer();
        applyStimulus(8'h30, 0, 1'b0);
        checkMessage("ok", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
